bp_be_late_wb_queue: RTL and testbench
======================================

Name: bp_be_late_wb_queue

Overview:
- Producer side of the late-writeback path. It collects results that retire after the normal pipeline writeback and sends them to the register-file write port.
- Two sources feed it: dcache miss fills (mem) and long-latency unit results (long).
- It buffers them in order and presents one late writeback per cycle. Each presented writeback clears the matching scoreboard entry in the integer or FP scoreboard.
- The register-file owner dequeues an entry only when the pipeline's own writeback slot is idle.

Parameters:
- data_width_p, 64, writeback data width.
- reg_addr_width_p, 5, register address width.
- els_p, 4, queue depth. Must be a power of 2 and ≥2.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- mem_v_i  in  1  dcache late-fill result valid
- mem_fp_i  in  1  1 = FP destination, 0 = integer destination
- mem_rd_addr_i  in  reg_addr_width_p  destination register
- mem_data_i  in  data_width_p  result data
- mem_ready_o  out  1  queue can accept mem this cycle
- long_v_i  in  1  long-unit result valid
- long_fp_i  in  1  1 = FP destination, 0 = integer destination
- long_rd_addr_i  in  reg_addr_width_p  destination register
- long_data_i  in  data_width_p  result data
- long_ready_o  out  1  queue can accept long this cycle
- wb_v_o  out  1  head entry valid
- wb_fp_o  out  1  head entry is an FP write (frd_w)
- wb_rd_addr_o  out  reg_addr_width_p  head destination register
- wb_data_o  out  data_width_p  head data
- wb_yumi_i  in  1  write port consumes the head this cycle
- count_o  out  $clog2(els_p+1)  number of stored entries
- empty_o  out  1  count_o==0
- full_o  out  1  count_o==els_p

Behaviour:
- Reset:
  - Asynchronous on reset_n_i low: count, read pointer and write pointer go to 0.
  - wb_v_o=0, empty_o=1, full_o=0, count_o=0; both readies follow from free=els_p.
  - Data storage is not reset.
  - Asserting reset mid-operation discards all entries immediately; no writeback is emitted afterwards.
- Handshake:
  - A source transfer occurs when X_v_i & X_ready_o (valid/ready).
  - The head transfer occurs when wb_v_o & wb_yumi_i (valid→yumi).
  - wb_yumi_i while wb_v_o=0 is illegal; the bench asserts on it.
- Readiness, with free = els_p − count (registered count only; the same-cycle dequeue is ignored so there is no yumi→ready path):
  - mem_ready_o = (free ≥ 1).
  - long_ready_o = (free ≥ 2) | (free==1 & ~mem_v_i).
  - mem has priority.
- Enqueue:
  - Up to 2 entries per cycle.
  - When both sources transfer in the same cycle, mem is written at wptr and long at wptr+1, so mem is older.
  - wptr advances by the number of stored entries, modulo els_p.
- Integer x0 filter:
  - A transfer with fp=0 and rd_addr=0 is accepted but not stored and does not advance wptr.
  - FP f0 is stored normally.
- Dequeue:
  - wb_* show the entry at rptr whenever count>0; there is no bypass.
  - Latency is 1 cycle: an entry written at edge N is visible after edge N.
  - On yumi, rptr advances by 1 modulo els_p.
- Count update: count_next = count + stored − dequeued. Legal values are 0..els_p.
- Simultaneous events:
  - Enqueue of 1 or 2 entries together with a dequeue in the same cycle is legal; count changes by the net amount.
  - When full, a dequeue does not make ready high in that same cycle; ready rises the next cycle.
- Ordering: strictly FIFO. Entries from different sources are ordered by acceptance cycle, with mem before long within a cycle.
- Outputs hold their values while wb_yumi_i=0 (stable head).
- Assertions: count never exceeds els_p; there is no enqueue while the corresponding ready=0.

Test Plan:
- Reset, then mem_v_i=1, fp=0, rd=5, data=0xAA → the next cycle shows wb_v_o=1, wb_rd_addr_o=5, wb_data_o=0xAA, count_o=1. Yumi → empty_o=1 on the following cycle.
- Same cycle mem(rd=3, 0x11) and long(fp=1, rd=7, 0x22), no yumi → head is rd3/0x11 with fp=0. After a yumi, head is rd7/0x22 with fp=1. count goes 2→1.
- Fill to count=3 with no yumi, then assert both valids → mem_ready_o=1, long_ready_o=0. Only mem is stored, count=4, full_o=1, both readies 0 next cycle.
- full_o=1 with yumi held every cycle for 6 cycles → the 4 entries drain in FIFO order, with wrap-around pointers correct. Ready stays 0 in the first yumi cycle and returns to 1 one cycle later.
- Integer rd=0 from mem together with long fp rd=0 → only the FP entry appears (count=1, wb_fp_o=1, wb_rd_addr_o=0).
- count=2 with reset_n_i pulsed low asynchronously mid-cycle → wb_v_o=0 and count_o=0 immediately. After release, no stale entries appear.

Source files
------------

// File: rtl/bp_be_late_wb_queue_if.sv
// Late-writeback queue bundle: two result sources in,
// one register-file writeback out, plus occupancy status.
interface bp_be_late_wb_queue_if #(
   parameter int data_width_p     = 64,
   parameter int reg_addr_width_p = 5,
   parameter int els_p            = 4
);
   logic                          mem_v_i;
   logic                          mem_fp_i;
   logic [reg_addr_width_p-1:0]   mem_rd_addr_i;
   logic [data_width_p-1:0]       mem_data_i;
   logic                          mem_ready_o;
   logic                          long_v_i;
   logic                          long_fp_i;
   logic [reg_addr_width_p-1:0]   long_rd_addr_i;
   logic [data_width_p-1:0]       long_data_i;
   logic                          long_ready_o;
   logic                          wb_v_o;
   logic                          wb_fp_o;
   logic [reg_addr_width_p-1:0]   wb_rd_addr_o;
   logic [data_width_p-1:0]       wb_data_o;
   logic                          wb_yumi_i;
   logic [$clog2(els_p+1)-1:0]    count_o;
   logic                          empty_o;
   logic                          full_o;

   modport master (
      output mem_v_i, mem_fp_i, mem_rd_addr_i, mem_data_i,
      output long_v_i, long_fp_i, long_rd_addr_i, long_data_i,
      output wb_yumi_i,
      input  mem_ready_o, long_ready_o,
      input  wb_v_o, wb_fp_o, wb_rd_addr_o, wb_data_o,
      input  count_o, empty_o, full_o
   );

   modport slave (
      input  mem_v_i, mem_fp_i, mem_rd_addr_i, mem_data_i,
      input  long_v_i, long_fp_i, long_rd_addr_i, long_data_i,
      input  wb_yumi_i,
      output mem_ready_o, long_ready_o,
      output wb_v_o, wb_fp_o, wb_rd_addr_o, wb_data_o,
      output count_o, empty_o, full_o
   );
endinterface

// File: rtl/bp_be_late_wb_queue.sv
// In-order queue of late-retiring results (dcache fills and
// long-latency ops) feeding the register-file late write port.
module bp_be_late_wb_queue #(
   parameter int data_width_p     = 64,
   parameter int reg_addr_width_p = 5,
   parameter int els_p            = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   bp_be_late_wb_queue_if.slave bus
);
   localparam int PTR_W = $clog2(els_p);
   localparam int CNT_W = $clog2(els_p+1);

   logic [data_width_p-1:0]     r_data [els_p];
   logic [reg_addr_width_p-1:0] r_rd   [els_p];
   logic [els_p-1:0]            r_fp;
   logic [PTR_W-1:0]            r_rptr;
   logic [PTR_W-1:0]            r_wptr;
   logic [CNT_W-1:0]            r_count;

   logic [CNT_W-1:0] w_free;
   logic             w_mem_xfer;
   logic             w_long_xfer;
   logic             w_mem_st;
   logic             w_long_st;
   logic             w_deq;
   logic [PTR_W-1:0] w_long_wptr;

   // Readiness looks only at the registered count, so there
   // is no combinational path from yumi to ready.
   assign w_free = CNT_W'(els_p) - r_count;

   assign bus.mem_ready_o  = (w_free >= CNT_W'(1));
   assign bus.long_ready_o = (w_free >= CNT_W'(2))
                           | ((w_free == CNT_W'(1))
                              & ~bus.mem_v_i);

   assign w_mem_xfer  = bus.mem_v_i  & bus.mem_ready_o;
   assign w_long_xfer = bus.long_v_i & bus.long_ready_o;

   // Writes to integer x0 are accepted and dropped.
   assign w_mem_st  = w_mem_xfer
                    & (bus.mem_fp_i | (|bus.mem_rd_addr_i));
   assign w_long_st = w_long_xfer
                    & (bus.long_fp_i | (|bus.long_rd_addr_i));

   assign w_long_wptr = r_wptr + PTR_W'(w_mem_st);

   assign w_deq = bus.wb_v_o & bus.wb_yumi_i;

   assign bus.wb_v_o       = (r_count != '0);
   assign bus.wb_fp_o      = r_fp[r_rptr];
   assign bus.wb_rd_addr_o = r_rd[r_rptr];
   assign bus.wb_data_o    = r_data[r_rptr];
   assign bus.count_o      = r_count;
   assign bus.empty_o      = (r_count == '0);
   assign bus.full_o       = (r_count == CNT_W'(els_p));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PTR_W'(w_mem_st)
                           + PTR_W'(w_long_st);
         r_rptr  <= r_rptr + PTR_W'(w_deq);
         r_count <= r_count + CNT_W'(w_mem_st)
                            + CNT_W'(w_long_st)
                            - CNT_W'(w_deq);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_mem_st) begin
         r_data[r_wptr] <= bus.mem_data_i;
         r_rd[r_wptr]   <= bus.mem_rd_addr_i;
         r_fp[r_wptr]   <= bus.mem_fp_i;
      end
      if (w_long_st) begin
         r_data[w_long_wptr] <= bus.long_data_i;
         r_rd[w_long_wptr]   <= bus.long_rd_addr_i;
         r_fp[w_long_wptr]   <= bus.long_fp_i;
      end
   end
endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// Directed bench for the late-writeback queue: a vector table
// for the main sequence, plus an async-reset corner case.
module tb_bp_be_late_wb_queue;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   bp_be_late_wb_queue_if #(
      .data_width_p(64), .reg_addr_width_p(5), .els_p(4)
   ) bus ();

   bp_be_late_wb_queue #(
      .data_width_p(64), .reg_addr_width_p(5), .els_p(4)
   ) dut (
      .clk_i(clk),
      .reset_n_i(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mv;
      logic        mfp;
      logic [4:0]  mrd;
      logic [63:0] md;
      logic        lv;
      logic        lfp;
      logic [4:0]  lrd;
      logic [63:0] ld;
      logic        y;
      logic        emr;
      logic        elr;
      logic        ev;
      logic        efp;
      logic [4:0]  erd;
      logic [63:0] ed;
      logic [2:0]  ec;
   } vec_t;

   vec_t tbl [16];

   function automatic vec_t mk(
      logic mv, logic mfp, logic [4:0] mrd, logic [63:0] md,
      logic lv, logic lfp, logic [4:0] lrd, logic [63:0] ld,
      logic y, logic emr, logic elr, logic ev, logic efp,
      logic [4:0] erd, logic [63:0] ed, logic [2:0] ec);
      vec_t v;
      v.mv = mv; v.mfp = mfp; v.mrd = mrd; v.md = md;
      v.lv = lv; v.lfp = lfp; v.lrd = lrd; v.ld = ld;
      v.y = y; v.emr = emr; v.elr = elr; v.ev = ev;
      v.efp = efp; v.erd = erd; v.ed = ed; v.ec = ec;
      return v;
   endfunction

   task automatic chk(string nm, logic [63:0] act,
                      logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus.mem_v_i        = v.mv;
      bus.mem_fp_i       = v.mfp;
      bus.mem_rd_addr_i  = v.mrd;
      bus.mem_data_i     = v.md;
      bus.long_v_i       = v.lv;
      bus.long_fp_i      = v.lfp;
      bus.long_rd_addr_i = v.lrd;
      bus.long_data_i    = v.ld;
      bus.wb_yumi_i      = v.y;
   endtask

   task automatic chk_state(string tag, logic ev, logic efp,
                            logic [4:0] erd, logic [63:0] ed,
                            logic [2:0] ec);
      chk({tag, ".wb_v"}, 64'(bus.wb_v_o), 64'(ev));
      chk({tag, ".count"}, 64'(bus.count_o), 64'(ec));
      chk({tag, ".empty"}, 64'(bus.empty_o), 64'(ec == 0));
      chk({tag, ".full"}, 64'(bus.full_o), 64'(ec == 4));
      if (ev) begin
         chk({tag, ".fp"}, 64'(bus.wb_fp_o), 64'(efp));
         chk({tag, ".rd"}, 64'(bus.wb_rd_addr_o), 64'(erd));
         chk({tag, ".data"}, bus.wb_data_o, ed);
      end
   endtask

   task automatic apply(int i, vec_t v);
      string tag;
      tag = $sformatf("v%0d", i);
      drive(v);
      #1;
      chk({tag, ".mem_rdy"}, 64'(bus.mem_ready_o), 64'(v.emr));
      chk({tag, ".long_rdy"}, 64'(bus.long_ready_o),
          64'(v.elr));
      if (v.y)
         chk({tag, ".yumi_legal"}, 64'(bus.wb_v_o), 64'd1);
      @(posedge clk);
      #1;
      chk_state(tag, v.ev, v.efp, v.erd, v.ed, v.ec);
      @(negedge clk);
   endtask

   vec_t idle;
   vec_t ld2;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      idle = mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0,0);
      drive(idle);

      //          mv mfp mrd md      lv lfp lrd ld      y  mr lr v fp rd ed      c
      tbl[0]  = mk(1,0,5,64'hAA,    0,0,0,0,        0, 1,1, 1,0,5,64'hAA,  1);
      tbl[1]  = mk(0,0,0,0,         0,0,0,0,        1, 1,1, 0,0,0,0,       0);
      tbl[2]  = mk(1,0,3,64'h11,    1,1,7,64'h22,   0, 1,1, 1,0,3,64'h11,  2);
      tbl[3]  = mk(0,0,0,0,         0,0,0,0,        1, 1,1, 1,1,7,64'h22,  1);
      tbl[4]  = mk(1,0,1,64'h101,   0,0,0,0,        0, 1,1, 1,1,7,64'h22,  2);
      tbl[5]  = mk(1,0,2,64'h102,   0,0,0,0,        0, 1,1, 1,1,7,64'h22,  3);
      tbl[6]  = mk(1,0,4,64'h104,   1,0,6,64'h106,  0, 1,0, 1,1,7,64'h22,  4);
      tbl[7]  = mk(0,0,0,0,         0,0,0,0,        0, 0,0, 1,1,7,64'h22,  4);
      tbl[8]  = mk(0,0,0,0,         0,0,0,0,        1, 0,0, 1,0,1,64'h101, 3);
      tbl[9]  = mk(0,0,0,0,         0,0,0,0,        1, 1,1, 1,0,2,64'h102, 2);
      tbl[10] = mk(0,0,0,0,         0,0,0,0,        1, 1,1, 1,0,4,64'h104, 1);
      tbl[11] = mk(0,0,0,0,         0,0,0,0,        1, 1,1, 0,0,0,0,       0);
      tbl[12] = mk(1,0,0,64'h55,    1,1,0,64'h66,   0, 1,1, 1,1,0,64'h66,  1);
      tbl[13] = mk(1,0,8,64'h88,    1,0,10,64'hAA0, 1, 1,1, 1,0,8,64'h88,  2);
      tbl[14] = mk(1,0,0,64'h77,    0,0,0,0,        1, 1,1, 1,0,10,64'hAA0,1);
      tbl[15] = mk(0,0,0,0,         0,0,0,0,        1, 1,1, 0,0,0,0,       0);

      repeat (2) @(negedge clk);
      #1;
      chk_state("rst", 0, 0, 0, 0, 0);
      chk("rst.mem_rdy", 64'(bus.mem_ready_o), 64'd1);
      chk("rst.long_rdy", 64'(bus.long_ready_o), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) apply(i, tbl[i]);

      // Load two entries, then drop reset between edges.
      ld2 = mk(1,0,3,64'h31, 1,0,4,64'h41, 0,
               1,1, 1,0,3,64'h31, 2);
      apply(100, ld2);
      drive(idle);
      @(posedge clk);
      #1;
      chk_state("pre_ar", 1, 0, 3, 64'h31, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("ar", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_state("post_ar", 0, 0, 0, 0, 0);
      @(negedge clk);
      apply(101, mk(1,1,12,64'hC, 0,0,0,0, 0,
                    1,1, 1,1,12,64'hC, 1));
      apply(102, mk(0,0,0,0, 0,0,0,0, 1,
                    1,1, 0,0,0,0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: sim time exceeded limit");
      $fatal(1);
   end
endmodule
